// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_DROP,
        S_HOLD
    } fetch_state_e;

    localparam logic [31:0] DefaultResetVector = 32'h0000_0000;

endpackage

// File: rtl/fetch_unit.sv
// Fetch stage: issues one imem request at a time and fills the F/D pipeline register.
// Redirects retarget the PC and squash any response still in flight.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DefaultResetVector
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PCNext_F,
    input  logic        Redirect_E,
    input  logic        Stall_D,
    input  logic        Flush_D,
    output logic        IReq_F,
    output logic [31:0] IAddr_F,
    input  logic        IGnt_F,
    input  logic        IRValid_F,
    input  logic [31:0] IRData_F,
    output logic [31:0] PC_F,
    output logic [31:0] PCPlus4_F,
    output logic [31:0] Instr_D,
    output logic [31:0] PC_D,
    output logic [31:0] PCPlus4_D,
    output logic        Valid_D
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  hold_q, hold_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  dpc_q, dpc_d;
    logic [31:0]  dpcp4_q, dpcp4_d;
    logic         valid_q, valid_d;

    logic         accept;
    logic         deliver;
    logic [31:0]  deliver_word;
    logic [31:0]  pc_plus4;

    assign pc_plus4 = pc_q + 32'd4;
    assign accept   = !valid_q || !Stall_D;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_REQ;
            pc_q    <= RESET_VECTOR;
            hold_q  <= '0;
            instr_q <= '0;
            dpc_q   <= '0;
            dpcp4_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            hold_q  <= hold_d;
            instr_q <= instr_d;
            dpc_q   <= dpc_d;
            dpcp4_q <= dpcp4_d;
            valid_q <= valid_d;
        end
    end

    // Next-state logic; a redirect always wins over delivery.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        hold_d       = hold_q;
        deliver      = 1'b0;
        deliver_word = IRData_F;

        unique case (state_q)
            S_REQ: begin
                if (Redirect_E) pc_d = PCNext_F;
                if (IGnt_F) state_d = Redirect_E ? S_DROP : S_WAIT;
            end
            S_WAIT: begin
                if (Redirect_E) begin
                    pc_d    = PCNext_F;
                    state_d = IRValid_F ? S_REQ : S_DROP;
                end else if (IRValid_F) begin
                    if (accept) begin
                        deliver = 1'b1;
                        state_d = S_REQ;
                    end else begin
                        hold_d  = IRData_F;
                        state_d = S_HOLD;
                    end
                end
            end
            S_DROP: begin
                if (Redirect_E) pc_d = PCNext_F;
                if (IRValid_F) state_d = S_REQ;
            end
            S_HOLD: begin
                if (Redirect_E) begin
                    pc_d    = PCNext_F;
                    hold_d  = '0;
                    state_d = S_REQ;
                end else if (accept) begin
                    deliver      = 1'b1;
                    deliver_word = hold_q;
                    state_d      = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase

        if (deliver) pc_d = PCNext_F;

        instr_d = instr_q;
        dpc_d   = dpc_q;
        dpcp4_d = dpcp4_q;
        valid_d = valid_q;
        if (deliver) begin
            instr_d = deliver_word;
            dpc_d   = pc_q;
            dpcp4_d = pc_plus4;
            valid_d = 1'b1;
        end else if (Flush_D) begin
            valid_d = 1'b0;
        end
    end

    // Outputs
    always_comb begin
        IReq_F    = (state_q == S_REQ) && !rst;
        IAddr_F   = pc_q;
        PC_F      = pc_q;
        PCPlus4_F = pc_plus4;
        Instr_D   = instr_q;
        PC_D      = dpc_q;
        PCPlus4_D = dpcp4_q;
        Valid_D   = valid_q;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter: RESET_VECTOR, 32'h0000_0000, PC_F value after reset.
REQ-002 SHALL have ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- PCNext_F  in  32  next PC from PC mux.
- Redirect_E  in  1  high when PCSrc_E != 2'b00.
- Stall_D  in  1  decode stage cannot accept.
- Flush_D  in  1  invalidate decode register.
- IReq_F  out  1  imem request valid.
- IAddr_F  out  32  imem request address.
- IGnt_F  in  1  imem accepts request.
- IRValid_F  in  1  imem response valid, single-cycle pulse.
- IRData_F  in  32  imem response word.
- PC_F  out  32  current fetch PC.
- PCPlus4_F  out  32  PC_F + 4, feeds PC mux.
- Instr_D, PC_D, PCPlus4_D  out  32 each  decode register contents.
- Valid_D  out  1  decode register holds a live instruction.

Function
REQ-003 SHALL compute PCPlus4_F = PC_F + 32'd4 combinationally, modulo 2^32; 32'hFFFF_FFFC wraps to 0.
REQ-004 SHALL allow at most one outstanding imem request.
REQ-005 SHALL implement four states:
- S_REQ: IReq_F=1, IAddr_F=PC_F.
- S_WAIT: awaiting response.
- S_DROP: awaiting stale response.
- S_HOLD: response buffered.
IReq_F SHALL be 0 in every state other than S_REQ.
REQ-006 S_REQ transitions:
- IGnt_F and Redirect_E: PC_F<=PCNext_F, go S_DROP.
- IGnt_F only: go S_WAIT.
- Redirect_E only: PC_F<=PCNext_F, stay S_REQ.
- IRValid_F in S_REQ SHALL be ignored.
REQ-007 S_WAIT transitions:
- IRValid_F and Redirect_E: discard response, PC_F<=PCNext_F, go S_REQ.
- Redirect_E without IRValid_F: PC_F<=PCNext_F, go S_DROP.
- IRValid_F and decode accepts: deliver, go S_REQ.
- IRValid_F and decode does not accept: buffer IRData_F, go S_HOLD.
REQ-008 S_DROP: on IRValid_F, discard and go S_REQ; on Redirect_E, PC_F<=PCNext_F and remain (same cycle as IRValid_F: go S_REQ).
REQ-009 S_HOLD: Redirect_E discards buffer, PC_F<=PCNext_F, go S_REQ; otherwise, when decode accepts, deliver buffer, go S_REQ.
REQ-010 Decode accepts SHALL mean (!Valid_D || !Stall_D).
REQ-011 Delivery SHALL load Instr_D, PC_D<=PC_F, PCPlus4_D<=PCPlus4_F, Valid_D<=1, and PC_F<=PCNext_F in the same edge.
REQ-012 Delivery SHALL occur in a cycle only if Redirect_E is low; Redirect_E has priority over delivery.
REQ-013 Flush_D SHALL clear Valid_D at the next edge unless a delivery occurs that edge, in which case the delivered instruction loads with Valid_D=1.
REQ-014 With Valid_D=1, Stall_D=1 and Flush_D=0, all decode outputs SHALL hold.
REQ-015 Best-case throughput SHALL be one instruction per two cycles with 1-cycle imem latency: request, then response.

Reset
REQ-016 On rst: PC_F=RESET_VECTOR, state S_REQ, Valid_D=0, Instr_D=PC_D=PCPlus4_D=0, buffer=0.
REQ-017 IReq_F SHALL be 0 in any cycle rst is high; rst mid-operation abandons the outstanding request, and the imem is reset by the same rst.

Structure
REQ-018 Package fetch_pkg SHALL hold the state enum (S_REQ, S_WAIT, S_DROP, S_HOLD) and the default RESET_VECTOR constant.
REQ-019 SHALL be a single module with no sub-modules; one 32-bit hold register, state register, PC register and decode register.

Verification
REQ-020 Reset release, IGnt_F=1 in the first cycle, 1-cycle response 32'h00500093 -> IAddr_F=0, then Instr_D=32'h00500093, PC_D=0, PCPlus4_D=4, Valid_D=1, PC_F=4.
REQ-021 Redirect_E=1 with PCNext_F=32'h100 while in S_WAIT -> next response dropped, next IAddr_F=32'h100, Valid_D unchanged.
REQ-022 Stall_D=1 with Valid_D=1 when a response arrives -> S_HOLD, decode outputs hold; Stall_D drops -> buffered word appears in Instr_D next edge, PC_F advances by 4.
REQ-023 Redirect_E and IGnt_F in the same S_REQ cycle -> S_DROP, and the following response is never delivered.
REQ-024 PC_F=32'hFFFF_FFFC -> PCPlus4_F=0, and delivery sets PCPlus4_D=0.
REQ-025 rst asserted in S_WAIT -> IReq_F=0 that cycle; after release PC_F=RESET_VECTOR and Valid_D=0.
